// File: rtl/process_scheduler.sv
// Round-robin preemptive process scheduler: tracks ready slots and resume PCs,
// and drives a registered context-switch request back into the program counter.
module process_scheduler #(
  parameter int NUM_PROC = 4,
  parameter int QUANTUM  = 20,
  parameter int ID_W     = $clog2(NUM_PROC)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [4:0]          pc_counter,
  input  logic [31:0]         pc_current,
  input  logic                exec_proc,
  input  logic                Halt,
  input  logic                jump_taken,
  input  logic                load_valid,
  input  logic [ID_W-1:0]     load_id,
  input  logic [31:0]         load_addr,
  output logic                change_pc,
  output logic [31:0]         pc_in,
  output logic [ID_W-1:0]     cur_proc,
  output logic [NUM_PROC-1:0] proc_ready,
  output logic                idle
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SELECT = 2'd2;
  localparam logic [1:0] ST_SWITCH = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [ID_W-1:0]     cur_q, cur_d, next_q, next_d;
  logic                has_cur_q, has_cur_d;
  logic [31:0]         pc_in_q, pc_in_d;
  logic                change_pc_q;
  logic [NUM_PROC-1:0] ready_all;
  logic [31:0]         saved_all [NUM_PROC];

  logic        halt_eff, load_ok, save_en;
  logic [31:0] pc_plus1;

  assign halt_eff = Halt && has_cur_q && (state_q != ST_IDLE);
  assign load_ok  = load_valid && !((load_id == cur_q) && has_cur_q && (state_q != ST_IDLE));
  // A halted process is never saved, even if its halt arrived while the switch was blocked.
  assign save_en  = (state_q == ST_SWITCH) && !jump_taken && !halt_eff && has_cur_q && ready_all[cur_q];
  assign pc_plus1 = pc_current + 32'd1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PROC; gi++) begin : g_slot
      logic        rdy_q, rdy_d;
      logic [31:0] pc_q, pc_d;

      always_comb begin
        rdy_d = rdy_q;
        pc_d  = pc_q;
        if (load_ok && (load_id == ID_W'(gi))) begin
          rdy_d = 1'b1;
          pc_d  = load_addr;
        end
        if (save_en && (cur_q == ID_W'(gi))) pc_d = pc_plus1;
        if (halt_eff && (cur_q == ID_W'(gi))) rdy_d = 1'b0;
      end

      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          rdy_q <= 1'b0;
          pc_q  <= 32'd0;
        end else begin
          rdy_q <= rdy_d;
          pc_q  <= pc_d;
        end
      end

      assign ready_all[gi] = rdy_q;
      assign saved_all[gi] = pc_q;
    end
  endgenerate

  // Rotate the candidate mask so bit 0 is slot cur+1; the current slot lands in the top bit.
  logic [NUM_PROC-1:0]   cand, rot;
  logic [2*NUM_PROC-1:0] dbl;
  logic [ID_W:0]         shamt;
  logic [ID_W-1:0]       sel_off, next_sel;
  logic                  found;

  assign cand     = ready_all & ~(halt_eff ? (NUM_PROC'(1) << cur_q) : '0);
  assign shamt    = {1'b0, cur_q} + (ID_W+1)'(1);
  assign dbl      = {cand, cand} >> shamt;
  assign rot      = dbl[NUM_PROC-1:0];
  assign found    = |rot;
  assign next_sel = cur_q + ID_W'(1) + sel_off;

  always_comb begin
    sel_off = '0;
    for (int k = NUM_PROC - 1; k >= 0; k--) begin
      if (rot[k]) sel_off = ID_W'(k);
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    next_d    = next_q;
    has_cur_d = has_cur_q;
    pc_in_d   = pc_in_q;
    case (state_q)
      ST_IDLE: begin
        if (|ready_all) state_d = ST_SELECT;
      end
      ST_RUN: begin
        if (halt_eff || (!exec_proc && (pc_counter >= 5'(QUANTUM)))) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (found) begin
          next_d  = next_sel;
          pc_in_d = saved_all[next_sel];
          state_d = ST_SWITCH;
        end else begin
          has_cur_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_SWITCH: begin
        if (halt_eff && (next_q == cur_q)) begin
          state_d = ST_SELECT;
        end else if (!jump_taken) begin
          cur_d     = next_q;
          has_cur_d = 1'b1;
          state_d   = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      next_q      <= '0;
      has_cur_q   <= 1'b0;
      pc_in_q     <= 32'd0;
      change_pc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      next_q      <= next_d;
      has_cur_q   <= has_cur_d;
      pc_in_q     <= pc_in_d;
      change_pc_q <= (state_d == ST_SWITCH);
    end
  end

  assign change_pc  = change_pc_q;
  assign pc_in      = pc_in_q;
  assign cur_proc   = cur_q;
  assign proc_ready = ready_all;
  assign idle       = (state_q == ST_IDLE);

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: directed vector table, reset-mid-switch sequence,
// and randomized traffic checked against a slot-level scheduling model.
module tb_process_scheduler;

  localparam int NP = 4;
  localparam int QT = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [4:0]  pc_counter = '0;
  logic [31:0] pc_current = '0;
  logic        exec_proc = 1'b0, Halt = 1'b0, jump_taken = 1'b0, load_valid = 1'b0;
  logic [1:0]  load_id = '0;
  logic [31:0] load_addr = '0;
  logic        change_pc, idle;
  logic [31:0] pc_in;
  logic [1:0]  cur_proc;
  logic [3:0]  proc_ready;

  process_scheduler #(.NUM_PROC(NP), .QUANTUM(QT)) dut (
    .Clock(Clock), .Reset(Reset), .pc_counter(pc_counter), .pc_current(pc_current),
    .exec_proc(exec_proc), .Halt(Halt), .jump_taken(jump_taken), .load_valid(load_valid),
    .load_id(load_id), .load_addr(load_addr), .change_pc(change_pc), .pc_in(pc_in),
    .cur_proc(cur_proc), .proc_ready(proc_ready), .idle(idle)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: slot table plus the phase of the current context switch.
  typedef enum int {M_IDLE, M_RUN, M_PICK, M_SWAP} mphase_t;
  mphase_t     m_phase;
  bit          m_ready [NP];
  logic [31:0] m_saved [NP];
  int          m_cur, m_next;
  bit          m_has;
  logic [31:0] m_pcin;

  task automatic model_reset();
    m_phase = M_IDLE; m_cur = 0; m_next = 0; m_has = 0; m_pcin = 0;
    for (int i = 0; i < NP; i++) begin m_ready[i] = 0; m_saved[i] = 0; end
  endtask

  task automatic model_step();
    bit          old_ready [NP];
    logic [31:0] old_saved [NP];
    bit          any, halt_eff, found;
    int          id;
    any = 0;
    for (int i = 0; i < NP; i++) begin
      old_ready[i] = m_ready[i]; old_saved[i] = m_saved[i];
      if (m_ready[i]) any = 1;
    end
    halt_eff = Halt && m_has && (m_phase != M_IDLE);
    if (load_valid && !(int'(load_id) == m_cur && m_has && m_phase != M_IDLE)) begin
      m_ready[load_id] = 1; m_saved[load_id] = load_addr;
    end
    if (halt_eff) m_ready[m_cur] = 0;
    case (m_phase)
      M_IDLE: if (any) m_phase = M_PICK;
      M_RUN:  if (halt_eff || (!exec_proc && int'(pc_counter) >= QT)) m_phase = M_PICK;
      M_PICK: begin
        found = 0;
        for (int k = 1; k <= NP; k++) begin
          id = (m_cur + k) % NP;
          if (!found && old_ready[id] && !(halt_eff && id == m_cur)) begin
            found = 1; m_next = id; m_pcin = old_saved[id];
          end
        end
        if (found) m_phase = M_SWAP;
        else begin m_has = 0; m_phase = M_IDLE; end
      end
      M_SWAP: begin
        if (halt_eff && m_next == m_cur) m_phase = M_PICK;
        else if (!jump_taken) begin
          if (m_has && old_ready[m_cur] && !halt_eff) m_saved[m_cur] = pc_current + 32'd1;
          m_cur = m_next; m_has = 1; m_phase = M_RUN;
        end
      end
      default: m_phase = M_IDLE;
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  typedef struct {
    logic lv; logic [1:0] lid; logic [31:0] laddr; logic [4:0] cnt; logic [31:0] pcc;
    logic ex; logic hl; logic jt;
    logic e_chg; logic [31:0] e_pcin; logic [1:0] e_cur; logic [3:0] e_rdy; logic e_idle;
  } vec_t;

  function automatic vec_t mk(input logic lv, input logic [1:0] lid, input logic [31:0] laddr,
                              input logic [4:0] cnt, input logic [31:0] pcc, input logic ex,
                              input logic hl, input logic jt, input logic e_chg,
                              input logic [31:0] e_pcin, input logic [1:0] e_cur,
                              input logic [3:0] e_rdy, input logic e_idle);
    vec_t v;
    v.lv = lv; v.lid = lid; v.laddr = laddr; v.cnt = cnt; v.pcc = pcc;
    v.ex = ex; v.hl = hl; v.jt = jt; v.e_chg = e_chg; v.e_pcin = e_pcin;
    v.e_cur = e_cur; v.e_rdy = e_rdy; v.e_idle = e_idle;
    return v;
  endfunction

  vec_t tbl [39];

  initial begin
    logic [3:0] mmask;
    bit         ok;
    int         shown;

    // Boot, round-robin, jump collision, halt, exec_proc inhibit, halt-after-self-select.
    tbl[0]  = mk(1, 0, 32'h10, 0, 0,     0, 0, 0,  0, 32'h00, 0, 4'b0001, 1);
    tbl[1]  = mk(0, 0, 0,      0, 0,     0, 0, 0,  0, 32'h00, 0, 4'b0001, 0);
    tbl[2]  = mk(0, 0, 0,      0, 0,     0, 0, 0,  1, 32'h10, 0, 4'b0001, 0);
    tbl[3]  = mk(0, 0, 0,      0, 0,     0, 0, 0,  0, 32'h10, 0, 4'b0001, 0);
    tbl[4]  = mk(1, 1, 32'h40, 1, 32'h10,0, 0, 0,  0, 32'h10, 0, 4'b0011, 0);
    tbl[5]  = mk(0, 0, 0,      4, 32'h11,0, 0, 0,  0, 32'h10, 0, 4'b0011, 0);
    tbl[6]  = mk(0, 0, 0,      5, 32'h12,0, 0, 0,  1, 32'h40, 0, 4'b0011, 0);
    tbl[7]  = mk(0, 0, 0,      6, 32'h13,0, 0, 0,  0, 32'h40, 1, 4'b0011, 0);
    tbl[8]  = mk(0, 0, 0,      4, 32'h45,0, 0, 0,  0, 32'h40, 1, 4'b0011, 0);
    tbl[9]  = mk(0, 0, 0,      5, 32'h46,0, 0, 0,  1, 32'h14, 1, 4'b0011, 0);
    tbl[10] = mk(0, 0, 0,      5, 32'h46,0, 0, 1,  1, 32'h14, 1, 4'b0011, 0);
    tbl[11] = mk(0, 0, 0,      5, 32'h47,0, 0, 1,  1, 32'h14, 1, 4'b0011, 0);
    tbl[12] = mk(0, 0, 0,      5, 32'h48,0, 0, 0,  0, 32'h14, 0, 4'b0011, 0);
    tbl[13] = mk(0, 0, 0,      4, 32'h15,0, 0, 0,  0, 32'h14, 0, 4'b0011, 0);
    tbl[14] = mk(0, 0, 0,      0, 32'h16,0, 0, 0,  1, 32'h49, 0, 4'b0011, 0);
    tbl[15] = mk(0, 0, 0,      0, 32'h20,0, 0, 0,  0, 32'h49, 1, 4'b0011, 0);
    tbl[16] = mk(1, 2, 32'h80, 0, 32'h49,0, 0, 0,  0, 32'h49, 1, 4'b0111, 0);
    tbl[17] = mk(0, 0, 0,      0, 32'h4a,0, 1, 0,  0, 32'h49, 1, 4'b0101, 0);
    tbl[18] = mk(0, 0, 0,      0, 32'h4b,0, 0, 0,  1, 32'h80, 1, 4'b0101, 0);
    tbl[19] = mk(0, 0, 0,      0, 32'h30,0, 0, 0,  0, 32'h80, 2, 4'b0101, 0);
    tbl[20] = mk(0, 0, 0,     25, 32'h80,1, 0, 0,  0, 32'h80, 2, 4'b0101, 0);
    tbl[21] = mk(0, 0, 0,     25, 32'h81,1, 0, 0,  0, 32'h80, 2, 4'b0101, 0);
    tbl[22] = mk(0, 0, 0,     25, 32'h82,0, 0, 0,  0, 32'h80, 2, 4'b0101, 0);
    tbl[23] = mk(0, 0, 0,      0, 32'h83,0, 0, 0,  1, 32'h21, 2, 4'b0101, 0);
    tbl[24] = mk(0, 0, 0,      0, 32'h84,0, 0, 0,  0, 32'h21, 0, 4'b0101, 0);
    tbl[25] = mk(0, 0, 0,      0, 32'h21,0, 1, 0,  0, 32'h21, 0, 4'b0100, 0);
    tbl[26] = mk(0, 0, 0,      0, 32'h22,0, 0, 0,  1, 32'h85, 0, 4'b0100, 0);
    tbl[27] = mk(0, 0, 0,      0, 32'h99,0, 1, 0,  0, 32'h85, 2, 4'b0100, 0);
    tbl[28] = mk(0, 0, 0,      0, 32'h85,0, 1, 0,  0, 32'h85, 2, 4'b0000, 0);
    tbl[29] = mk(0, 0, 0,      0, 32'h86,0, 0, 0,  0, 32'h85, 2, 4'b0000, 1);
    tbl[30] = mk(0, 0, 0,      0, 32'h87,0, 0, 0,  0, 32'h85, 2, 4'b0000, 1);
    tbl[31] = mk(1, 3, 32'hC0, 0, 0,     0, 0, 0,  0, 32'h85, 2, 4'b1000, 1);
    tbl[32] = mk(0, 0, 0,      0, 0,     0, 0, 0,  0, 32'h85, 2, 4'b1000, 0);
    tbl[33] = mk(0, 0, 0,      0, 0,     0, 0, 0,  1, 32'hC0, 2, 4'b1000, 0);
    tbl[34] = mk(0, 0, 0,      0, 0,     0, 0, 0,  0, 32'hC0, 3, 4'b1000, 0);
    tbl[35] = mk(0, 0, 0,      4, 32'hC1,0, 0, 0,  0, 32'hC0, 3, 4'b1000, 0);
    tbl[36] = mk(0, 0, 0,      0, 32'hC2,0, 0, 0,  1, 32'hC0, 3, 4'b1000, 0);
    tbl[37] = mk(0, 0, 0,      0, 32'hC3,0, 1, 1,  0, 32'hC0, 3, 4'b0000, 0);
    tbl[38] = mk(0, 0, 0,      0, 32'hC4,0, 0, 0,  0, 32'hC0, 3, 4'b0000, 1);

    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    chk("reset change_pc", 32'(change_pc), 32'd0);
    chk("reset pc_in", pc_in, 32'd0);
    chk("reset cur_proc", 32'(cur_proc), 32'd0);
    chk("reset proc_ready", 32'(proc_ready), 32'd0);
    chk("reset idle", 32'(idle), 32'd1);
    Reset = 1'b0;

    for (int i = 0; i < 39; i++) begin
      load_valid = tbl[i].lv; load_id = tbl[i].lid; load_addr = tbl[i].laddr;
      pc_counter = tbl[i].cnt; pc_current = tbl[i].pcc; exec_proc = tbl[i].ex;
      Halt = tbl[i].hl; jump_taken = tbl[i].jt;
      tick();
      chk($sformatf("row%0d change_pc", i), 32'(change_pc), 32'(tbl[i].e_chg));
      chk($sformatf("row%0d pc_in", i), pc_in, tbl[i].e_pcin);
      chk($sformatf("row%0d cur_proc", i), 32'(cur_proc), 32'(tbl[i].e_cur));
      chk($sformatf("row%0d proc_ready", i), 32'(proc_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d idle", i), 32'(idle), 32'(tbl[i].e_idle));
      $display("row %0d: chg=%0b pc_in=%h cur=%0d rdy=%b idle=%0b", i, change_pc, pc_in, cur_proc, proc_ready, idle);
    end

    // Reset asserted in the middle of a SWITCH interval.
    load_valid = 1'b1; load_id = 2'd1; load_addr = 32'h50; Halt = 1'b0; jump_taken = 1'b0;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    chk("preswitch change_pc", 32'(change_pc), 32'd1);
    chk("preswitch pc_in", pc_in, 32'h50);
    Reset = 1'b1;
    #1;
    chk("midreset change_pc", 32'(change_pc), 32'd0);
    chk("midreset pc_in", pc_in, 32'd0);
    chk("midreset cur_proc", 32'(cur_proc), 32'd0);
    chk("midreset proc_ready", 32'(proc_ready), 32'd0);
    chk("midreset idle", 32'(idle), 32'd1);
    $display("midreset: chg=%0b pc_in=%h rdy=%b idle=%0b", change_pc, pc_in, proc_ready, idle);
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();

    shown = 0;
    for (int c = 0; c < 3000; c++) begin
      load_valid = ($urandom_range(0, 5) == 0);
      load_id    = 2'($urandom_range(0, 3));
      load_addr  = $urandom;
      pc_counter = 5'($urandom_range(0, 7));
      pc_current = $urandom;
      exec_proc  = ($urandom_range(0, 3) == 0);
      Halt       = ($urandom_range(0, 11) == 0);
      jump_taken = ($urandom_range(0, 2) == 0);
      tick();
      for (int i = 0; i < NP; i++) mmask[i] = m_ready[i];
      ok = (change_pc === (m_phase == M_SWAP)) && (pc_in === m_pcin) &&
           (cur_proc === 2'(m_cur)) && (proc_ready === mmask) && (idle === (m_phase == M_IDLE));
      n_cmp++;
      if (!ok) begin
        n_bad++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random cycle %0d: got chg=%0b pc_in=%h cur=%0d rdy=%b idle=%0b want chg=%0b pc_in=%h cur=%0d rdy=%b idle=%0b",
                   c, change_pc, pc_in, cur_proc, proc_ready, idle,
                   (m_phase == M_SWAP), m_pcin, m_cur, mmask, (m_phase == M_IDLE));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
